// File: rtl/game_pkg.sv
// Shared definitions for the jump-game sequencer: state encodings and timing defaults.
package game_pkg;

    localparam int unsigned STATE_W         = 3;
    localparam int unsigned FRAME_DIV_50MHZ = 833333;

    typedef enum logic [STATE_W-1:0] {
        StMenu  = 3'd0,
        StWait  = 3'd1,
        StPlay  = 3'd2,
        StPause = 3'd3,
        StOver  = 3'd4
    } state_e;

    // The frame divider only advances while the game or the game-over screen is live.
    function automatic logic is_running(state_e s);
        return (s == StPlay) || (s == StOver);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a registered one-cycle tick every DIV enabled cycles.
module tick_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW    = $clog2(DIV);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LastCnt) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: menu, play, pause and game-over hold, with lives, saturating score
// and retained high score.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned FRAME_DIV        = FRAME_DIV_50MHZ,
    parameter int unsigned SCORE_W          = 8,
    parameter int unsigned LIVES            = 3,
    parameter int unsigned OVER_HOLD_FRAMES = 120
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               pause_btn,
    input  logic               endgame,
    output logic               startgame,
    output logic               paused,
    output logic               game_over,
    output logic               frame_tick,
    output logic               respawn,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         lives_left,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned        HoldW    = $clog2(OVER_HOLD_FRAMES + 1);
    localparam logic [HoldW-1:0]   HoldLast = HoldW'(OVER_HOLD_FRAMES - 1);
    localparam logic [SCORE_W-1:0] ScoreMax = '1;

    state_e state_q, state_d;

    logic go_meta_q, go_sync_q, go_prev_q, go_rise_q;
    logic pb_meta_q, pb_sync_q, pb_prev_q, pause_rise_q;

    logic startgame_q, startgame_d;
    logic paused_q, paused_d;
    logic game_over_q, game_over_d;
    logic respawn_q, respawn_d;

    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [2:0]         lives_q, lives_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               hold_expire;

    // Two-flop synchronisers followed by a registered rising-edge detector.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            go_meta_q    <= 1'b0;
            go_sync_q    <= 1'b0;
            go_prev_q    <= 1'b0;
            go_rise_q    <= 1'b0;
            pb_meta_q    <= 1'b0;
            pb_sync_q    <= 1'b0;
            pb_prev_q    <= 1'b0;
            pause_rise_q <= 1'b0;
        end else begin
            go_meta_q    <= go;
            go_sync_q    <= go_meta_q;
            go_prev_q    <= go_sync_q;
            go_rise_q    <= go_sync_q & ~go_prev_q;
            pb_meta_q    <= pause_btn;
            pb_sync_q    <= pb_meta_q;
            pb_prev_q    <= pb_sync_q;
            pause_rise_q <= pb_sync_q & ~pb_prev_q;
        end
    end

    tick_divider #(
        .DIV (FRAME_DIV)
    ) u_frame_div (
        .clk    (clk),
        .resetn (resetn),
        .en     (is_running(state_q)),
        .clr    (state_q == StMenu),
        .tick   (frame_tick)
    );

    assign hold_expire = (state_q == StOver) && frame_tick && (hold_q == HoldLast);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StMenu;
        end else begin
            state_q <= state_d;
        end
    end

    // endgame takes precedence over a coincident pause edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMenu:  if (go_rise_q) state_d = StWait;
            StWait:  state_d = StPlay;
            StPlay: begin
                if (endgame) begin
                    if (lives_q <= 3'd1) state_d = StOver;
                end else if (pause_rise_q) begin
                    state_d = StPause;
                end
            end
            StPause: if (pause_rise_q) state_d = StPlay;
            StOver:  if (go_rise_q || hold_expire) state_d = StMenu;
            default: state_d = StMenu;
        endcase
    end

    always_comb begin
        startgame_d = (state_d == StPlay);
        paused_d    = (state_d == StPause);
        game_over_d = (state_d == StOver);
    end

    always_comb begin
        lives_d   = lives_q;
        score_d   = score_q;
        high_d    = high_q;
        hold_d    = '0;
        respawn_d = 1'b0;
        unique case (state_q)
            StMenu: if (go_rise_q) score_d = '0;
            StWait: lives_d = 3'(LIVES);
            StPlay: begin
                if (endgame) begin
                    if (lives_q > 3'd1) begin
                        lives_d   = lives_q - 3'd1;
                        respawn_d = 1'b1;
                    end else begin
                        lives_d = '0;
                        if (score_q > high_q) high_d = score_q;
                    end
                end else if (frame_tick && (score_q != ScoreMax)) begin
                    score_d = score_q + 1'b1;
                end
            end
            StOver:  hold_d = frame_tick ? hold_q + 1'b1 : hold_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            startgame_q <= 1'b0;
            paused_q    <= 1'b0;
            game_over_q <= 1'b0;
            respawn_q   <= 1'b0;
            score_q     <= '0;
            high_q      <= '0;
            lives_q     <= 3'(LIVES);
            hold_q      <= '0;
        end else begin
            startgame_q <= startgame_d;
            paused_q    <= paused_d;
            game_over_q <= game_over_d;
            respawn_q   <= respawn_d;
            score_q     <= score_d;
            high_q      <= high_d;
            lives_q     <= lives_d;
            hold_q      <= hold_d;
        end
    end

    assign startgame  = startgame_q;
    assign paused     = paused_q;
    assign game_over  = game_over_q;
    assign respawn    = respawn_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign lives_left = lives_q;
    assign state      = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random buttons, checked every cycle
// against a frame/phase-level reference model.
module tb_game_ctrl;

    localparam int FD   = 4;
    localparam int SW   = 4;
    localparam int NL   = 2;
    localparam int HOLD = 3;
    localparam int SMAX = (1 << SW) - 1;

    localparam int MENU = 0, WAIT = 1, PLAY = 2, PAUSE = 3, OVER = 4;

    logic          clk = 1'b0;
    logic          resetn, go, pause_btn, endgame;
    logic          startgame, paused, game_over, frame_tick, respawn;
    logic [SW-1:0] score, high_score;
    logic [2:0]    lives_left, state;

    game_ctrl #(
        .FRAME_DIV        (FD),
        .SCORE_W          (SW),
        .LIVES            (NL),
        .OVER_HOLD_FRAMES (HOLD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .pause_btn  (pause_btn),
        .endgame    (endgame),
        .startgame  (startgame),
        .paused     (paused),
        .game_over  (game_over),
        .frame_tick (frame_tick),
        .respawn    (respawn),
        .score      (score),
        .high_score (high_score),
        .lives_left (lives_left),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: game state, lives, score, frame phase within FD, hold frames seen.
    int m_state, m_lives, m_score, m_high, m_phase, m_hold;
    bit m_tick, m_resp;
    bit go_h[$];
    bit pb_h[$];

    task automatic model_reset();
        m_state = MENU; m_lives = NL; m_score = 0; m_high = 0;
        m_phase = 0; m_hold = 0; m_tick = 0; m_resp = 0;
        go_h = {};
        pb_h = {};
        repeat (5) begin
            go_h.push_back(1'b0);
            pb_h.push_back(1'b0);
        end
    endtask

    // One clock edge. A button level sampled at edge k is acted on at edge k+3.
    task automatic model_step();
        int n, ns, nl, nsc, nh, np, nhold;
        bit gr, pr, nt, nr;
        go_h.push_back(go);
        pb_h.push_back(pause_btn);
        n  = go_h.size();
        gr = go_h[n-4] && !go_h[n-5];
        pr = pb_h[n-4] && !pb_h[n-5];
        if (n > 8) begin
            void'(go_h.pop_front());
            void'(pb_h.pop_front());
        end
        ns = m_state; nl = m_lives; nsc = m_score; nh = m_high; nhold = m_hold;
        nt = 0; nr = 0; np = m_phase;
        if (m_state == MENU) np = 0;
        else if (m_state == PLAY || m_state == OVER) begin
            np = (m_phase + 1) % FD;
            nt = (np == 0);
        end
        case (m_state)
            MENU: if (gr) begin ns = WAIT; nsc = 0; end
            WAIT: begin nl = NL; ns = PLAY; end
            PLAY: begin
                if (endgame) begin
                    if (m_lives > 1) begin nl = m_lives - 1; nr = 1; end
                    else begin
                        nl = 0; ns = OVER; nhold = 0;
                        if (m_score > m_high) nh = m_score;
                    end
                end else begin
                    if (m_tick && m_score < SMAX) nsc = m_score + 1;
                    if (pr) ns = PAUSE;
                end
            end
            PAUSE: if (pr) ns = PLAY;
            OVER: begin
                if (gr) ns = MENU;
                else if (m_tick) begin
                    nhold = m_hold + 1;
                    if (nhold == HOLD) ns = MENU;
                end
            end
            default: ;
        endcase
        m_state = ns; m_lives = nl; m_score = nsc; m_high = nh;
        m_phase = np; m_hold = nhold; m_tick = nt; m_resp = nr;
    endtask

    task automatic compare_all();
        check_eq("state",      int'(state),      m_state);
        check_eq("startgame",  int'(startgame),  int'(m_state == PLAY));
        check_eq("paused",     int'(paused),     int'(m_state == PAUSE));
        check_eq("game_over",  int'(game_over),  int'(m_state == OVER));
        check_eq("frame_tick", int'(frame_tick), int'(m_tick));
        check_eq("respawn",    int'(respawn),    int'(m_resp));
        check_eq("score",      int'(score),      m_score);
        check_eq("high_score", int'(high_score), m_high);
        check_eq("lives_left", int'(lives_left), m_lives);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"}, int'(state), MENU);
        check_eq({tag, "_flags"}, int'({startgame, paused, game_over, frame_tick, respawn}), 0);
        check_eq({tag, "_score"}, int'(score), 0);
        check_eq({tag, "_high"},  int'(high_score), 0);
        check_eq({tag, "_lives"}, int'(lives_left), NL);
    endtask

    task automatic press_go_to_play();
        int n;
        go = 1'b0;
        repeat (4) cyc();
        go = 1'b1;
        n = 0;
        while (state != 3'(PLAY) && n < 20) begin cyc(); n++; end
        go = 1'b0;
        check_eq("reach_play", int'(state), PLAY);
    endtask

    initial begin
        int t_wait, t_play, t_tick, ticks, n;
        resetn = 1'b1; go = 1'b0; pause_btn = 1'b0; endgame = 1'b0;
        #1 resetn = 1'b0;
        #2 check_reset_values("por");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (3) cyc();

        // Start latency and first frame tick
        go = 1'b1;
        t_wait = -1; t_play = -1; t_tick = -1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (state == 3'(WAIT) && t_wait < 0) t_wait = i;
            if (state == 3'(PLAY) && t_play < 0) t_play = i;
            if (frame_tick && t_tick < 0) t_tick = i;
            if (i == 6) go = 1'b0;
        end
        check_eq("go_to_wait_cycles", t_wait, 4);
        check_eq("go_to_play_cycles", t_play, 5);
        check_eq("start_to_tick_cycles", t_tick - t_play, 4);
        check_eq("lives_at_start", int'(lives_left), NL);

        ticks = 0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (frame_tick) ticks++;
        end
        check_eq("ticks_in_80", ticks, 20);
        check_eq("score_saturated", int'(score), SMAX);

        // Lose a life, then the last one
        endgame = 1'b1; cyc(); endgame = 1'b0;
        check_eq("respawn_pulse", int'(respawn), 1);
        check_eq("lives_after_hit", int'(lives_left), 1);
        check_eq("state_after_hit", int'(state), PLAY);
        cyc();
        check_eq("respawn_one_cycle", int'(respawn), 0);
        endgame = 1'b1; cyc(); endgame = 1'b0;
        check_eq("over_state", int'(state), OVER);
        check_eq("over_lives", int'(lives_left), 0);
        check_eq("high_from_score", int'(high_score), SMAX);

        // Hold screen expiry
        ticks = 0; n = 0;
        while (state == 3'(OVER) && n < 40) begin
            if (frame_tick) ticks++;
            cyc(); n++;
        end
        check_eq("over_exit_menu", int'(state), MENU);
        check_eq("over_hold_ticks", ticks, HOLD);

        // go in OVER
        press_go_to_play();
        repeat (2) cyc();
        endgame = 1'b1; cyc(); endgame = 1'b0;
        cyc();
        endgame = 1'b1; cyc(); endgame = 1'b0;
        check_eq("over_again", int'(state), OVER);
        check_eq("high_kept", int'(high_score), SMAX);
        go = 1'b1; n = 0;
        while (state == 3'(OVER) && n < 10) begin cyc(); n++; end
        go = 1'b0;
        check_eq("go_in_over_cycles", n, 4);

        // Pause: frozen divider, endgame ignored
        press_go_to_play();
        repeat (3) cyc();
        pause_btn = 1'b1; n = 0;
        while (state != 3'(PAUSE) && n < 10) begin cyc(); n++; end
        check_eq("enter_pause", int'(state), PAUSE);
        cyc();
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) pause_btn = 1'b0;
            endgame = (i == 3);
            cyc();
            if (frame_tick) ticks++;
        end
        endgame = 1'b0;
        check_eq("pause_no_ticks", ticks, 0);
        check_eq("pause_lives", int'(lives_left), NL);
        pause_btn = 1'b1; n = 0;
        while (state != 3'(PLAY) && n < 10) begin cyc(); n++; end
        check_eq("resume_play", int'(state), PLAY);
        repeat (8) cyc();

        // endgame coincident with pause edge
        pause_btn = 1'b0;
        repeat (4) cyc();
        pause_btn = 1'b1;
        repeat (3) cyc();
        endgame = 1'b1; cyc(); endgame = 1'b0;
        check_eq("coinc_lives", int'(lives_left), 1);
        check_eq("coinc_state", int'(state), PLAY);
        repeat (3) cyc();
        check_eq("coinc_stays_play", int'(state), PLAY);
        pause_btn = 1'b0;

        // Random buttons and collisions
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) go = ~go;
            if ($urandom_range(0, 15) == 0) pause_btn = ~pause_btn;
            endgame = ($urandom_range(0, 11) == 0);
            cyc();
        end
        endgame = 1'b0; go = 1'b0; pause_btn = 1'b0;
        repeat (4) cyc();
        if (state == 3'(PAUSE)) begin
            pause_btn = 1'b1; repeat (5) cyc(); pause_btn = 1'b0;
        end
        for (int r = 0; r < 10 && state != 3'(PLAY); r++) begin
            go = 1'b1; repeat (5) cyc();
            go = 1'b0; repeat (5) cyc();
        end
        repeat (3) cyc();
        check_eq("pre_reset_play", int'(state), PLAY);

        // Asynchronous reset mid-game
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check_reset_values("async");
        @(negedge clk);
        check_reset_values("held");
        resetn = 1'b1;
        model_reset();
        repeat (10) cyc();
        press_go_to_play();
        repeat (12) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
